alu_operand_collector: RTL and testbench
========================================

Name: alu_operand_collector

Overview:
- Issue-to-execute stage directly upstream of the ALU.
- Accepts one decoded instruction at a time: opcode, up to three source register indices, one destination index.
- Reads source registers sequentially through a single register-file read port with 1-cycle latency, then presents the assembled operand set and destination to the ALU with a valid/ready handshake.
- Snoops the writeback bus so collected operands never go stale while the instruction waits.

Parameters:
- DATA_W, 32, operand and register width
- RADDR_W, 5, register index width

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  instruction offered
- in_ready  out  1  collector can accept an instruction
- in_opcode  in  alu_opcode_e  ALU operation
- in_src1, in_src2, in_src3  in  RADDR_W  source register indices
- in_dst  in  RADDR_W  destination register index
- rf_rd_en  out  1  register-file read strobe
- rf_rd_addr  out  RADDR_W  read address
- rf_rd_data  in  DATA_W  read data, valid the cycle after rf_rd_en
- wb_valid  in  1  writeback occurring this cycle
- wb_addr  in  RADDR_W  writeback register
- wb_data  in  DATA_W  writeback value
- out_valid  out  1  operand set ready for ALU
- out_ready  in  1  ALU/issue accepts operand set
- out_opcode  out  alu_opcode_e  to ALU opcode
- out_operand1, out_operand2, out_operand3  out  DATA_W  to ALU operands
- out_dst  out  RADDR_W  destination, forwarded to writeback

Behaviour:
- Clock clk; reset rst_n is synchronous, active-low.
- Reset values:
  - in_ready=0 during reset, 1 in the first cycle after release.
  - rf_rd_en=0, rf_rd_addr=0, out_valid=0.
  - all out_* data fields = 0; opcode = OP_ADD.
- Source count n = num_srcs(opcode), defined in the package: OP_FMA→3, OP_RELU→1, all others→2.
- FSM states: IDLE, READ, LAST, DISPATCH.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: latch opcode/srcs/dst, clear operand slots to 0, go to READ with read index k=1.
- READ:
  - in_ready=0; rf_rd_en=1; rf_rd_addr=src_k.
  - rf_rd_data for the read issued in the previous cycle is captured into slot k-1.
  - After issuing read n, go to LAST.
- LAST:
  - rf_rd_en=0; capture slot n; go to DISPATCH.
- DISPATCH:
  - out_valid=1; outputs are stable and unchanged while out_valid&&!out_ready, except writeback forwarding.
  - On out_valid&&out_ready: return to IDLE. No same-cycle accept; the next in_valid is accepted the cycle after.
- Latency: the accept cycle is cycle 0. Reads occur in cycles 1..n; out_valid is first high in cycle n+2. Throughput is one instruction per n+3 cycles when out_ready=1.
- Unused operand slots (index > n) output 0.
- Writeback forwarding: in READ/LAST/DISPATCH, each slot j whose read has been issued and whose src_j==wb_addr with wb_valid=1 takes wb_data at the edge.
  - wb_data has priority over rf_rd_data captured on the same edge.
  - Duplicate source indices are all updated.
  - Slots not yet read are not updated; the register file supplies the new value. The RF is write-before-read, so a same-cycle read sees the new value.
- Reset mid-operation (any state): return to IDLE next edge with reset values; the in-flight instruction is dropped and rf_rd_data arriving after reset is ignored.
- Holding in_valid while in_ready=0 has no effect; inputs are sampled only at accept.

Decomposition:
- warp_pkg gains:
  - alu_opcode_e (existing)
  - collector_state_e {IDLE, READ, LAST, DISPATCH}
  - function num_srcs(alu_opcode_e) returning 2 bits
  - constant MAX_SRCS=3
- No sub-module. The collector is a single FSM plus a 3-slot operand array with a per-slot forwarding comparator.

Test Plan:
- ADD, RF r1=0x10, r2=0x20, src1=1, src2=2, dst=3; accept at cycle 0 → rf reads addr1 at cycle 1 and addr2 at cycle 2; out_valid rises at cycle 4 with operand1=0x10, operand2=0x20, operand3=0, dst=3.
- FMA, r4=2, r5=3, r6=4 → three reads at cycles 1-3; out_valid at cycle 5 with operands 2/3/4; in_ready=0 from cycle 1 until the cycle after handshake.
- RELU, src1=7 (r7=0xFFFFFFFF) → single read; out_valid at cycle 3; operand1=0xFFFFFFFF, operand2=operand3=0.
- Backpressure: out_ready=0 for 5 cycles in DISPATCH → out_valid held, outputs stable, in_valid ignored; out_ready=1 → handshake, in_ready=1 the next cycle.
- Forwarding: ADD src1=1, src2=1; in DISPATCH drive wb_valid=1, wb_addr=1, wb_data=0x99 → operand1 and operand2 both 0x99 next cycle. Repeat with writeback on the capture edge of src1 → wb_data wins.
- Reset: assert rst_n=0 for one cycle during READ of an FMA → next cycle IDLE, out_valid=0, rf_rd_en=0. A following ADD completes normally with the correct latency.

Source files
------------

// File: rtl/warp_pkg.sv
// Shared warp-pipeline types: ALU opcodes, collector FSM states and source-count helper.
package warp_pkg;

    localparam int unsigned MAX_SRCS = 3;
    localparam int unsigned OPC_W    = 4;

    typedef enum logic [OPC_W-1:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_XOR  = 4'd4,
        OP_SLL  = 4'd5,
        OP_SRL  = 4'd6,
        OP_FMA  = 4'd7,
        OP_RELU = 4'd8
    } alu_opcode_e;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        READ     = 2'd1,
        LAST     = 2'd2,
        DISPATCH = 2'd3
    } collector_state_e;

    function automatic logic [1:0] num_srcs(input alu_opcode_e op);
        case (op)
            OP_FMA:  return 2'd3;
            OP_RELU: return 2'd1;
            default: return 2'd2;
        endcase
    endfunction

endpackage

// File: rtl/alu_operand_collector.sv
// Gathers up to three source operands through one 1-cycle RF read port and
// hands the operand set to the ALU, keeping collected values fresh from writeback.
module alu_operand_collector
    import warp_pkg::*;
#(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned RADDR_W = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  alu_opcode_e        in_opcode,
    input  logic [RADDR_W-1:0] in_src1,
    input  logic [RADDR_W-1:0] in_src2,
    input  logic [RADDR_W-1:0] in_src3,
    input  logic [RADDR_W-1:0] in_dst,
    output logic               rf_rd_en,
    output logic [RADDR_W-1:0] rf_rd_addr,
    input  logic [DATA_W-1:0]  rf_rd_data,
    input  logic               wb_valid,
    input  logic [RADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0]  wb_data,
    output logic               out_valid,
    input  logic               out_ready,
    output alu_opcode_e        out_opcode,
    output logic [DATA_W-1:0]  out_operand1,
    output logic [DATA_W-1:0]  out_operand2,
    output logic [DATA_W-1:0]  out_operand3,
    output logic [RADDR_W-1:0] out_dst
);

    collector_state_e     state_q, state_d;
    logic                 in_ready_q, in_ready_d;
    logic                 rf_rd_en_q, rf_rd_en_d;
    logic [RADDR_W-1:0]   rf_rd_addr_q, rf_rd_addr_d;
    logic [1:0]           rd_slot_q, rd_slot_d;
    logic [1:0]           n_q, n_d;
    logic                 pend_q, pend_d;
    logic [1:0]           pend_slot_q, pend_slot_d;
    logic [MAX_SRCS-1:0]  issued_q, issued_d;
    logic                 out_valid_q, out_valid_d;
    alu_opcode_e          opcode_q, opcode_d;
    logic [RADDR_W-1:0]   dst_q, dst_d;
    logic [RADDR_W-1:0]   src_q [MAX_SRCS];
    logic [RADDR_W-1:0]   src_d [MAX_SRCS];
    logic [DATA_W-1:0]    slot_q [MAX_SRCS];
    logic [DATA_W-1:0]    slot_d [MAX_SRCS];

    always_comb begin
        state_d      = state_q;
        in_ready_d   = in_ready_q;
        rf_rd_en_d   = 1'b0;
        rf_rd_addr_d = '0;
        rd_slot_d    = rd_slot_q;
        n_d          = n_q;
        pend_d       = rf_rd_en_q;
        pend_slot_d  = rd_slot_q;
        issued_d     = issued_q;
        out_valid_d  = out_valid_q;
        opcode_d     = opcode_q;
        dst_d        = dst_q;
        src_d        = src_q;
        slot_d       = slot_q;

        // RF data lands one cycle after the read; a writeback seen after issue overrides it.
        for (int unsigned j = 0; j < MAX_SRCS; j++) begin
            if (rf_rd_en_q && rd_slot_q == 2'(j)) begin
                issued_d[j] = 1'b1;
            end
            if (state_q != IDLE) begin
                if (pend_q && pend_slot_q == 2'(j)) begin
                    slot_d[j] = rf_rd_data;
                end
                if (issued_q[j] && wb_valid && src_q[j] == wb_addr) begin
                    slot_d[j] = wb_data;
                end
            end
        end

        case (state_q)
            IDLE: begin
                in_ready_d = 1'b1;
                if (in_valid && in_ready_q) begin
                    state_d      = READ;
                    in_ready_d   = 1'b0;
                    opcode_d     = in_opcode;
                    dst_d        = in_dst;
                    src_d[0]     = in_src1;
                    src_d[1]     = in_src2;
                    src_d[2]     = in_src3;
                    n_d          = num_srcs(in_opcode);
                    slot_d       = '{default: '0};
                    issued_d     = '0;
                    rf_rd_en_d   = 1'b1;
                    rf_rd_addr_d = in_src1;
                    rd_slot_d    = 2'd0;
                end
            end
            READ: begin
                if (rd_slot_q + 2'd1 == n_q) begin
                    state_d = LAST;
                end else begin
                    rf_rd_en_d = 1'b1;
                    rd_slot_d  = rd_slot_q + 2'd1;
                    for (int unsigned j = 0; j < MAX_SRCS; j++) begin
                        if (2'(j) == rd_slot_q + 2'd1) begin
                            rf_rd_addr_d = src_q[j];
                        end
                    end
                end
            end
            LAST: begin
                state_d     = DISPATCH;
                out_valid_d = 1'b1;
            end
            DISPATCH: begin
                if (out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            in_ready_q   <= 1'b0;
            rf_rd_en_q   <= 1'b0;
            rf_rd_addr_q <= '0;
            rd_slot_q    <= '0;
            n_q          <= '0;
            pend_q       <= 1'b0;
            pend_slot_q  <= '0;
            issued_q     <= '0;
            out_valid_q  <= 1'b0;
            opcode_q     <= OP_ADD;
            dst_q        <= '0;
            src_q        <= '{default: '0};
            slot_q       <= '{default: '0};
        end else begin
            state_q      <= state_d;
            in_ready_q   <= in_ready_d;
            rf_rd_en_q   <= rf_rd_en_d;
            rf_rd_addr_q <= rf_rd_addr_d;
            rd_slot_q    <= rd_slot_d;
            n_q          <= n_d;
            pend_q       <= pend_d;
            pend_slot_q  <= pend_slot_d;
            issued_q     <= issued_d;
            out_valid_q  <= out_valid_d;
            opcode_q     <= opcode_d;
            dst_q        <= dst_d;
            src_q        <= src_d;
            slot_q       <= slot_d;
        end
    end

    assign in_ready     = in_ready_q;
    assign rf_rd_en     = rf_rd_en_q;
    assign rf_rd_addr   = rf_rd_addr_q;
    assign out_valid    = out_valid_q;
    assign out_opcode   = opcode_q;
    assign out_dst      = dst_q;
    assign out_operand1 = slot_q[0];
    assign out_operand2 = slot_q[1];
    assign out_operand3 = slot_q[2];

endmodule

// File: tb/tb_alu_operand_collector.sv
// Bench for alu_operand_collector: RF model with write-before-read, directed and random instructions.
module tb_alu_operand_collector;
    import warp_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    alu_opcode_e in_opcode;
    logic [4:0]  in_src1, in_src2, in_src3, in_dst;
    logic        rf_rd_en;
    logic [4:0]  rf_rd_addr;
    logic [31:0] rf_rd_data;
    logic        wb_valid;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        out_valid;
    logic        out_ready;
    alu_opcode_e out_opcode;
    logic [31:0] out_operand1, out_operand2, out_operand3;
    logic [4:0]  out_dst;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] rf_mem [32];

    alu_operand_collector #(.DATA_W(32), .RADDR_W(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
        .in_src1(in_src1), .in_src2(in_src2), .in_src3(in_src3), .in_dst(in_dst),
        .rf_rd_en(rf_rd_en), .rf_rd_addr(rf_rd_addr), .rf_rd_data(rf_rd_data),
        .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_opcode(out_opcode),
        .out_operand1(out_operand1), .out_operand2(out_operand2), .out_operand3(out_operand3),
        .out_dst(out_dst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file: a read returns the value written in the same cycle.
    always @(posedge clk) begin
        if (rf_rd_en)
            rf_rd_data <= (wb_valid && wb_addr == rf_rd_addr) ? wb_data : rf_mem[rf_rd_addr];
        if (wb_valid)
            rf_mem[wb_addr] <= wb_data;
    end

    function automatic int ref_nsrc(input alu_opcode_e op);
        if (op == OP_FMA)  return 3;
        if (op == OP_RELU) return 1;
        return 2;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_wb(input int c, input int fc, input logic [4:0] fa,
                          input logic [31:0] fd, input bit rnd);
        if (c == fc) begin
            wb_valid = 1'b1; wb_addr = fa; wb_data = fd;
        end else if (rnd && $urandom_range(1, 0) == 1) begin
            wb_valid = 1'b1; wb_addr = 5'($urandom_range(7, 0)); wb_data = $urandom;
        end else begin
            wb_valid = 1'b0;
        end
    endtask

    task automatic check_operands(input logic [4:0] s [3], input int n, input string tag);
        logic [31:0] exp [3];
        for (int j = 0; j < 3; j++) exp[j] = (j < n) ? rf_mem[s[j]] : 32'h0;
        check({tag, "_op1"}, out_operand1, exp[0]);
        check({tag, "_op2"}, out_operand2, exp[1]);
        check({tag, "_op3"}, out_operand3, exp[2]);
    endtask

    task automatic run_instr(input alu_opcode_e op, input logic [4:0] s1, input logic [4:0] s2,
                             input logic [4:0] s3, input logic [4:0] d, input int stall,
                             input int fc, input logic [4:0] fa, input logic [31:0] fd,
                             input bit rnd, input string tag);
        logic [4:0] src [3];
        int n;
        int waited;
        src[0] = s1; src[1] = s2; src[2] = s3;
        n = ref_nsrc(op);
        waited = 0;
        while (in_ready !== 1'b1 && waited < 10) begin
            step();
            waited++;
        end
        check({tag, "_accept_ready"}, 32'(in_ready), 32'd1);
        if (in_ready !== 1'b1) return;
        // cycle 0: accept
        in_valid = 1'b1; in_opcode = op;
        in_src1 = s1; in_src2 = s2; in_src3 = s3; in_dst = d;
        out_ready = 1'b0;
        set_wb(0, fc, fa, fd, rnd);
        step();
        // cycles 1..n: reads; offered junk must be ignored
        for (int c = 1; c <= n; c++) begin
            in_opcode = alu_opcode_e'(4'($urandom_range(8, 0)));
            in_src1 = 5'($urandom); in_src2 = 5'($urandom);
            in_src3 = 5'($urandom); in_dst = 5'($urandom);
            check({tag, "_rd_en"}, 32'(rf_rd_en), 32'd1);
            check({tag, "_rd_addr"}, 32'(rf_rd_addr), 32'(src[c-1]));
            check({tag, "_busy_ready"}, 32'(in_ready), 32'd0);
            check({tag, "_early_valid"}, 32'(out_valid), 32'd0);
            set_wb(c, fc, fa, fd, rnd);
            step();
        end
        // cycle n+1: last capture
        check({tag, "_last_rd_en"}, 32'(rf_rd_en), 32'd0);
        check({tag, "_last_valid"}, 32'(out_valid), 32'd0);
        set_wb(n + 1, fc, fa, fd, rnd);
        step();
        // cycles n+2..: dispatch, held for stall cycles
        for (int s = 0; s <= stall; s++) begin
            check({tag, "_out_valid"}, 32'(out_valid), 32'd1);
            check({tag, "_disp_ready"}, 32'(in_ready), 32'd0);
            check({tag, "_disp_rd_en"}, 32'(rf_rd_en), 32'd0);
            check({tag, "_opcode"}, 32'(out_opcode), 32'(op));
            check({tag, "_dst"}, 32'(out_dst), 32'(d));
            check_operands(src, n, tag);
            out_ready = (s == stall);
            set_wb(n + 2 + s, fc, fa, fd, rnd);
            step();
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        wb_valid = 1'b0;
        check({tag, "_post_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_post_ready"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_opcode = OP_ADD;
        in_src1 = '0; in_src2 = '0; in_src3 = '0; in_dst = '0;
        wb_valid = 1'b0; wb_addr = '0; wb_data = '0; out_ready = 1'b0;
        step(); step(); step();
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_rd_en", 32'(rf_rd_en), 32'd0);
        check("rst_rd_addr", 32'(rf_rd_addr), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_opcode", 32'(out_opcode), 32'(OP_ADD));
        check("rst_op1", out_operand1, 32'd0);
        check("rst_op2", out_operand2, 32'd0);
        check("rst_op3", out_operand3, 32'd0);
        check("rst_dst", 32'(out_dst), 32'd0);
        rst_n = 1'b1;
        step();
        check("release_in_ready", 32'(in_ready), 32'd1);

        // Preload the register file through the writeback bus.
        for (int i = 0; i < 32; i++) begin
            wb_valid = 1'b1; wb_addr = 5'(i);
            case (i)
                1: wb_data = 32'h10;
                2: wb_data = 32'h20;
                4: wb_data = 32'd2;
                5: wb_data = 32'd3;
                6: wb_data = 32'd4;
                7: wb_data = 32'hFFFF_FFFF;
                default: wb_data = $urandom;
            endcase
            step();
        end
        wb_valid = 1'b0;

        run_instr(OP_ADD,  5'd1, 5'd2, 5'd9, 5'd3, 0, -1, 5'd0, 32'd0, 1'b0, "add");
        run_instr(OP_FMA,  5'd4, 5'd5, 5'd6, 5'd8, 0, -1, 5'd0, 32'd0, 1'b0, "fma");
        run_instr(OP_RELU, 5'd7, 5'd3, 5'd4, 5'd9, 0, -1, 5'd0, 32'd0, 1'b0, "relu");
        run_instr(OP_SUB,  5'd5, 5'd6, 5'd0, 5'd2, 5, -1, 5'd0, 32'd0, 1'b0, "stall");
        run_instr(OP_ADD,  5'd1, 5'd1, 5'd0, 5'd4, 2, 4, 5'd1, 32'h99, 1'b0, "fwd_disp");
        run_instr(OP_ADD,  5'd1, 5'd1, 5'd0, 5'd4, 0, 2, 5'd1, 32'h77, 1'b0, "fwd_capture");
        check("fwd_value", rf_mem[1], 32'h77);

        // Reset during READ of an FMA drops it.
        in_valid = 1'b1; in_opcode = OP_FMA;
        in_src1 = 5'd4; in_src2 = 5'd5; in_src3 = 5'd6; in_dst = 5'd1;
        step();
        in_valid = 1'b0;
        step();
        rst_n = 1'b0;
        step();
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_rd_en", 32'(rf_rd_en), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd0);
        rst_n = 1'b1;
        step();
        check("midrst_out_valid2", 32'(out_valid), 32'd0);
        run_instr(OP_ADD, 5'd1, 5'd2, 5'd0, 5'd3, 0, -1, 5'd0, 32'd0, 1'b0, "after_rst");

        for (int k = 0; k < 40; k++) begin
            run_instr(alu_opcode_e'(4'($urandom_range(8, 0))),
                      5'($urandom_range(7, 0)), 5'($urandom_range(7, 0)),
                      5'($urandom_range(7, 0)), 5'($urandom),
                      int'($urandom_range(3, 0)), -1, 5'd0, 32'd0, 1'b1, "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
